// File: rtl/fe_mul_arbiter.sv
// Round-robin arbiter sharing one sequential fe_mul among NREQ group-operation FSMs.
// Latches the winner's operands, sequences start/done and returns the product with a one-cycle pulse.
module fe_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 320
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_f,
  input  logic [NREQ*W-1:0] req_g,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_h,
  output logic              busy,
  output logic              mul_start,
  output logic [W-1:0]      mul_f,
  output logic [W-1:0]      mul_g,
  input  logic              mul_done,
  input  logic [W-1:0]      mul_h
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] owner;
  logic [IW-1:0] grant_idx;
  logic          grant_found;
  logic          accept;
  logic [W-1:0]  op_f, op_g;

  // Search begins one past the previous winner so every requester is served within NREQ-1 operations.
  always_comb begin : rr_search
    int            idx;
    logic [IW-1:0] idx_v;
    // NOTE: every variable written in a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    grant_idx   = '0;
    grant_found = 1'b0;
    idx         = 0;
    idx_v       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx   = (int'(last_grant) + k) % NREQ;
      idx_v = IW'(idx);
      if (!grant_found && req_valid[idx_v]) begin
        grant_found = 1'b1;
        grant_idx   = idx_v;
      end
    end
  end

  assign accept    = (state == IDLE) && grant_found && reset;
  assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mul_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mul_done is only honoured in WAIT; a done in any other state leaves everything untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= IW'(NREQ - 1);
      owner      <= '0;
      op_f       <= '0;
      op_g       <= '0;
      rsp_h      <= '0;
      rsp_valid  <= '0;
      mul_start  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      mul_start <= accept;
      rsp_valid <= '0;
      if (accept) begin
        op_f       <= req_f[int'(grant_idx)*W +: W];
        op_g       <= req_g[int'(grant_idx)*W +: W];
        owner      <= grant_idx;
        last_grant <= grant_idx;
      end
      if (state == WAIT && mul_done) begin
        rsp_h     <= mul_h;
        rsp_valid <= NREQ'(1) << owner;
      end
    end
  end

  assign mul_f = op_f;
  assign mul_g = op_g;

endmodule

// File: doc/fe_mul_arbiter.md
# fe_mul_arbiter

Round-robin scheduler that shares one sequential field multiplier (fe_mul, start/done handshake, 320-bit limb operands) among up to NREQ point-arithmetic requesters such as ge_madd, ge_add and ge_p2_dbl. It accepts one multiply request at a time and latches its operands. It sequences the multiplier's start/done handshake and returns the product to the owning requester with a one-cycle response pulse. It sits between the group-operation FSMs and a single fe_mul instance; it does not instantiate fe_mul.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 320, operand/product width in bits (packed limb format used by fe_mul)

- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  request i pending; f/g stable while high
- req_f  input  NREQ*W  operand f of requester i at bits [i*W +: W]
- req_g  input  NREQ*W  operand g of requester i at bits [i*W +: W]
- req_ready  output  NREQ  one-hot, combinational: request i accepted this cycle
- rsp_valid  output  NREQ  one-hot, registered, one-cycle pulse: product for requester i on rsp_h
- rsp_h  output  W  registered product, held until next capture
- busy  output  1  registered, high whenever state is not IDLE
- mul_start  output  1  one-cycle start pulse to fe_mul
- mul_f  output  W  latched operand f to fe_mul
- mul_g  output  W  latched operand g to fe_mul
- mul_done  input  1  fe_mul completion, product valid on mul_h this cycle
- mul_h  input  W  fe_mul product

## Operation
- Four states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid is high, select winner i by round-robin. Assert req_ready[i] only. Latch req_f/req_g slice i into op_f/op_g, record owner=i, set last_grant=i, go to ISSUE. If nothing is pending, stay in IDLE.
- Round-robin: search starts at (last_grant+1) mod NREQ and wraps. last_grant resets to NREQ-1, so requester 0 wins first.
- ISSUE: mul_start=1 for exactly this cycle, then go to WAIT.
- WAIT: hold mul_f/mul_g. When mul_done=1, capture rsp_h<=mul_h and go to RESP. Otherwise stay in WAIT; there is no timeout.
- RESP: rsp_valid[owner]=1 for this cycle only, then go to IDLE.
- mul_f/mul_g always drive op_f/op_g. They change only on an IDLE accept.
- mul_done outside WAIT (IDLE, ISSUE, RESP) is ignored. No state or output changes.
- Requester contract:
  - A requester drops req_valid in the cycle after its req_ready.
  - If req_valid is still high in the next IDLE, that is a new request.
  - Operands may change freely after req_ready.
- Requests arriving in ISSUE/WAIT/RESP wait. req_ready stays 0 outside IDLE.
- No arithmetic is done in this block; operands pass bit-exact.

## Timing
- Reset values, asserted immediately and asynchronously:
  - state=IDLE, last_grant=NREQ-1, owner=0
  - op_f=op_g=0, so mul_f=mul_g=0
  - rsp_h=0, rsp_valid=0, mul_start=0, busy=0
  - req_ready=0 while reset is low
- Accept in cycle T (IDLE): req_ready[i]=1 in T. mul_start=1 in T+1; busy=1 from T+1.
- mul_done high in cycle D ≥ T+2: rsp_valid[i]=1 and rsp_h valid in D+1. In D+2 the block is back in IDLE and can accept.
- End-to-end: response in D+1, i.e. multiplier latency plus 3 cycles of overhead per operation.
- Reset low mid-operation (any state): abort immediately to reset values with no rsp_valid; the in-flight product is discarded. fe_mul shares the same reset.
- All requesters valid continuously: grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 operations.

## Test plan
- Single request:
  - Stimulus: requester 0, f=3, g=5 (limb 0 only), mock multiplier with 4-cycle latency returning f*g.
  - Required: req_ready[0] in cycle T; mul_start in T+1; mul_done in T+5; rsp_valid=4'b0001 and rsp_h=15 in T+6; busy low in T+7.
- Contention:
  - Stimulus: req_valid=4'b1111 from reset, each requester re-raises after its response.
  - Required: grant order 0,1,2,3,0. Each rsp_valid pulse is one cycle and matches the owner; products are k*(k+1) for requester k with f=k, g=k+1.
- Fairness after wrap:
  - Stimulus: after last_grant=3, assert 4'b1010.
  - Required: requester 1 is granted before 3; with 4'b0101 and last_grant=0, requester 2 is granted before 0.
- Operand isolation:
  - Stimulus: requester 2 changes req_f to 0xFFFF the cycle after req_ready.
  - Required: mul_f keeps the original value through WAIT, and rsp_h equals the original product.
- Spurious done:
  - Stimulus: pulse mul_done in IDLE and in ISSUE.
  - Required: no rsp_valid, rsp_h unchanged, state sequence unaffected.
- Reset in WAIT:
  - Stimulus: drop reset two cycles after mul_start.
  - Required: all outputs go to reset values immediately, and no rsp_valid is ever issued for that request. After release, requester 0 again has first priority.
